// File: rtl/player_motion_ctrl.sv
// Player motion controller: paced, saturating position updates from held keys,
// and a rate-limited fire request with a req/ack handshake toward the bullet manager.
module player_motion_ctrl #(
    parameter int POS_W    = 10,
    parameter int X_MIN    = 0,
    parameter int X_MAX    = 600,
    parameter int Y_MIN    = 0,
    parameter int Y_MAX    = 440,
    parameter int X_INIT   = 300,
    parameter int Y_INIT   = 400,
    parameter int STEP     = 4,
    parameter int MOVE_DIV = 2,
    parameter int COOLDOWN = 25
) (
    input  logic             clk_100Hz,
    input  logic             rst_p,
    input  logic [3:0]       move_opr,
    input  logic             shoot_sign,
    input  logic             fire_ack,
    output logic [POS_W-1:0] pos_x,
    output logic [POS_W-1:0] pos_y,
    output logic             fire_req,
    output logic [POS_W-1:0] fire_x,
    output logic [POS_W-1:0] fire_y,
    output logic             cooling
);

    localparam int MC_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam int CC_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

    // Thresholds are one bit wider than the bus so the compares cannot wrap.
    localparam logic [POS_W:0]   X_LO   = (POS_W+1)'(X_MIN + STEP);
    localparam logic [POS_W:0]   X_HI   = (POS_W+1)'(X_MAX - STEP);
    localparam logic [POS_W:0]   Y_LO   = (POS_W+1)'(Y_MIN + STEP);
    localparam logic [POS_W:0]   Y_HI   = (POS_W+1)'(Y_MAX - STEP);
    localparam logic [POS_W-1:0] STEP_P = POS_W'(STEP);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        COOL = 2'd2
    } state_t;

    state_t            state, state_nx;
    logic [MC_W-1:0]   mcnt;
    logic [CC_W-1:0]   ccnt, ccnt_nx;
    logic              req_nx, cool_nx;
    logic [POS_W-1:0]  fx_nx, fy_nx;
    logic [POS_W-1:0]  x_nx, y_nx;
    logic              moving, step;
    logic              up, down, left, right;

    assign up     = move_opr[3];
    assign down   = move_opr[2];
    assign left   = move_opr[1];
    assign right  = move_opr[0];
    assign moving = (move_opr != 4'b0000);
    assign step   = moving && (mcnt == MC_W'(MOVE_DIV - 1));

    always_comb begin
        x_nx = pos_x;
        y_nx = pos_y;
        if (step) begin
            if (left && !right)
                x_nx = ({1'b0, pos_x} < X_LO) ? POS_W'(X_MIN) : pos_x - STEP_P;
            else if (right && !left)
                x_nx = ({1'b0, pos_x} > X_HI) ? POS_W'(X_MAX) : pos_x + STEP_P;
            if (up && !down)
                y_nx = ({1'b0, pos_y} < Y_LO) ? POS_W'(Y_MIN) : pos_y - STEP_P;
            else if (down && !up)
                y_nx = ({1'b0, pos_y} > Y_HI) ? POS_W'(Y_MAX) : pos_y + STEP_P;
        end
    end

    always_ff @(posedge clk_100Hz) begin
        if (rst_p) begin
            pos_x <= POS_W'(X_INIT);
            pos_y <= POS_W'(Y_INIT);
            mcnt  <= '0;
        end else begin
            pos_x <= x_nx;
            pos_y <= y_nx;
            if (!moving || step)
                mcnt <= '0;
            else
                mcnt <= mcnt + MC_W'(1);
        end
    end

    always_ff @(posedge clk_100Hz) begin
        if (rst_p) begin
            state    <= IDLE;
            fire_req <= 1'b0;
            fire_x   <= '0;
            fire_y   <= '0;
            cooling  <= 1'b0;
            ccnt     <= '0;
        end else begin
            state    <= state_nx;
            fire_req <= req_nx;
            fire_x   <= fx_nx;
            fire_y   <= fy_nx;
            cooling  <= cool_nx;
            ccnt     <= ccnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        req_nx   = fire_req;
        fx_nx    = fire_x;
        fy_nx    = fire_y;
        cool_nx  = cooling;
        ccnt_nx  = ccnt;
        case (state)
            IDLE: begin
                req_nx  = 1'b0;
                cool_nx = 1'b0;
                if (shoot_sign) begin
                    fx_nx    = pos_x;
                    fy_nx    = pos_y;
                    req_nx   = 1'b1;
                    state_nx = REQ;
                end
            end
            // A released fire key does not withdraw a request already posted.
            REQ: begin
                if (fire_req && fire_ack) begin
                    req_nx   = 1'b0;
                    ccnt_nx  = CC_W'(COOLDOWN - 1);
                    cool_nx  = 1'b1;
                    state_nx = COOL;
                end
            end
            COOL: begin
                if (ccnt == '0) begin
                    cool_nx  = 1'b0;
                    state_nx = IDLE;
                end else begin
                    ccnt_nx = ccnt - CC_W'(1);
                end
            end
            default: begin
                req_nx   = 1'b0;
                cool_nx  = 1'b0;
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Directed bench for player_motion_ctrl: a vector table for motion/clamping,
// plus hand-written sequences for the fire handshake, cooldown and resets.
module tb_player_motion_ctrl;

    logic       clk = 1'b0;
    logic       rst_p;
    logic [3:0] move_opr;
    logic       shoot_sign, fire_ack;
    logic [9:0] pos_x, pos_y, fire_x, fire_y;
    logic       fire_req, cooling;

    // Second instance starts near the low corner with one step per cycle.
    logic [3:0] b_move;
    logic       b_shoot, b_ack;
    logic [9:0] b_x, b_y, b_fx, b_fy;
    logic       b_req, b_cool;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    player_motion_ctrl dut (
        .clk_100Hz(clk), .rst_p(rst_p), .move_opr(move_opr), .shoot_sign(shoot_sign),
        .fire_ack(fire_ack), .pos_x(pos_x), .pos_y(pos_y), .fire_req(fire_req),
        .fire_x(fire_x), .fire_y(fire_y), .cooling(cooling)
    );

    player_motion_ctrl #(.X_INIT(2), .Y_INIT(2), .MOVE_DIV(1)) dut_b (
        .clk_100Hz(clk), .rst_p(rst_p), .move_opr(b_move), .shoot_sign(b_shoot),
        .fire_ack(b_ack), .pos_x(b_x), .pos_y(b_y), .fire_req(b_req),
        .fire_x(b_fx), .fire_y(b_fy), .cooling(b_cool)
    );

    typedef struct {
        logic [3:0] mv;
        logic       shoot;
        logic       ack;
        int         cyc;
        int         ex;
        int         ey;
        logic       ereq;
        logic       ecool;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(logic [3:0] mv, logic ack, int cyc, int ex, int ey);
        vec_t v;
        v.mv = mv; v.shoot = 1'b0; v.ack = ack; v.cyc = cyc;
        v.ex = ex; v.ey = ey; v.ereq = 1'b0; v.ecool = 1'b0;
        return v;
    endfunction

    task automatic tick(int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(string name, int act, int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        tbl[0]  = mk(4'b0001, 1'b0, 10,  320, 400); // 5 steps right
        tbl[1]  = mk(4'b0001, 1'b0, 1,   320, 400); // half period, no step
        tbl[2]  = mk(4'b0000, 1'b0, 1,   320, 400); // release clears pacing
        tbl[3]  = mk(4'b0001, 1'b0, 1,   320, 400); // restarts from zero
        tbl[4]  = mk(4'b0000, 1'b0, 1,   320, 400);
        tbl[5]  = mk(4'b0011, 1'b0, 20,  320, 400); // left+right cancel
        tbl[6]  = mk(4'b1001, 1'b0, 2,   324, 396); // diagonal up-right
        tbl[7]  = mk(4'b1100, 1'b1, 20,  324, 396); // up+down cancel, stray ack in IDLE
        tbl[8]  = mk(4'b0110, 1'b0, 4,   316, 404); // down-left, 2 steps
        tbl[9]  = mk(4'b0001, 1'b0, 200, 600, 404); // clamp right
        tbl[10] = mk(4'b1000, 1'b0, 250, 600, 0);   // clamp top
        tbl[11] = mk(4'b0100, 1'b0, 240, 600, 440); // clamp bottom
        tbl[12] = mk(4'b0010, 1'b0, 400, 0,   440); // clamp left

        b_move = 4'b0000; b_shoot = 1'b0; b_ack = 1'b0;

        // Reset with random inputs.
        rst_p = 1'b1;
        move_opr = 4'($urandom); shoot_sign = 1'($urandom); fire_ack = 1'($urandom);
        tick(2);
        check("reset pos_x", pos_x, 300);
        check("reset pos_y", pos_y, 400);
        check("reset fire_req", fire_req, 0);
        check("reset cooling", cooling, 0);
        check("reset fire_x", fire_x, 0);
        rst_p = 1'b0; move_opr = 4'b0000; shoot_sign = 1'b0; fire_ack = 1'b0;

        // Low-corner clamp on the second instance (starts at 2,2).
        check("b init x", b_x, 2);
        b_move = 4'b1010;
        tick();
        check("b clamp left", b_x, 0);
        check("b clamp up", b_y, 0);
        tick();
        check("b hold x", b_x, 0);
        check("b hold y", b_y, 0);
        b_move = 4'b0000;

        foreach (tbl[i]) begin
            move_opr = tbl[i].mv; shoot_sign = tbl[i].shoot; fire_ack = tbl[i].ack;
            tick(tbl[i].cyc);
            check($sformatf("vec%0d pos_x", i), pos_x, tbl[i].ex);
            check($sformatf("vec%0d pos_y", i), pos_y, tbl[i].ey);
            check($sformatf("vec%0d fire_req", i), fire_req, tbl[i].ereq);
            check($sformatf("vec%0d cooling", i), cooling, tbl[i].ecool);
        end
        move_opr = 4'b0000; fire_ack = 1'b0;

        // Fire while moving right from (0,440): origin frozen at press position.
        move_opr = 4'b0001; shoot_sign = 1'b1;
        tick();
        check("req rise", fire_req, 1);
        check("fire_x press", fire_x, 0);
        check("fire_y press", fire_y, 440);
        tick();
        check("req hold 2", fire_req, 1);
        check("pos moves during req", pos_x, 4);
        check("fire_x held", fire_x, 0);
        tick();
        check("req hold 3", fire_req, 1);
        move_opr = 4'b0000; fire_ack = 1'b1;
        tick();
        check("req drop on ack", fire_req, 0);
        check("cooling on ack", cooling, 1);
        fire_ack = 1'b0;

        // Cooldown with shoot held; acks during COOL are ignored.
        for (int k = 1; k <= 24; k++) begin
            fire_ack = (k >= 5 && k <= 8);
            tick();
            check($sformatf("cool k%0d", k), cooling, 1);
            check($sformatf("cool req k%0d", k), fire_req, 0);
        end
        fire_ack = 1'b0;
        tick();
        check("cool end", cooling, 0);
        check("no req yet", fire_req, 0);
        tick();
        check("refire 26 after ack", fire_req, 1);
        check("refire x", fire_x, 4);
        check("refire y", fire_y, 440);

        // Releasing shoot does not cancel the pending request.
        shoot_sign = 1'b0;
        tick(2);
        check("req survives release", fire_req, 1);

        // Reset in REQ, then a late ack.
        rst_p = 1'b1;
        tick();
        check("rst in REQ req", fire_req, 0);
        check("rst in REQ cool", cooling, 0);
        check("rst in REQ pos_x", pos_x, 300);
        rst_p = 1'b0; fire_ack = 1'b1;
        tick();
        check("late ack req", fire_req, 0);
        check("late ack cool", cooling, 0);

        // Reset in COOL.
        fire_ack = 1'b0; shoot_sign = 1'b1;
        tick();
        check("req for cool test", fire_req, 1);
        fire_ack = 1'b1; shoot_sign = 1'b0;
        tick();
        check("enter cool", cooling, 1);
        fire_ack = 1'b0;
        tick(3);
        check("still cool", cooling, 1);
        rst_p = 1'b1;
        tick();
        check("rst in COOL cool", cooling, 0);
        check("rst in COOL req", fire_req, 0);
        rst_p = 1'b0; fire_ack = 1'b1;
        tick();
        check("late ack after cool rst", cooling, 0);
        fire_ack = 1'b0; shoot_sign = 1'b1;
        tick();
        check("fires at once from IDLE", fire_req, 1);
        check("fire_x after rst", fire_x, 300);
        check("fire_y after rst", fire_y, 400);
        shoot_sign = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
